// File: rtl/multi_iter_hs.sv
// multi_iter_hs: iterative unsigned DATA_WIDTH x DATA_WIDTH multiplier with
// valid/ready handshakes on both sides, output backpressure and a zero early exit.
// Ports: clk, rst_n (async, active-low)
//        in_valid/in_ready/dat1/dat2  operand side
//        out_valid/out_ready/product  result side
//        busy                         high while calculating or holding a result
module multi_iter_hs #(
  parameter int DATA_WIDTH = 2048,
  parameter int LIMB_WIDTH = 32,
  parameter int MUL_LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     dat1,
  input  logic [DATA_WIDTH-1:0]     dat2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic                      busy
);

  localparam int N   = DATA_WIDTH / LIMB_WIDTH;
  localparam int P   = N / MUL_LANES;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int LW  = LIMB_WIDTH;
  localparam int GRP = MUL_LANES * LIMB_WIDTH;
  localparam int GW  = (MUL_LANES + 1) * LIMB_WIDTH;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int JW  = (P > 1) ? $clog2(P) : 1;
  localparam int SW  = $clog2(PW) + 1;

  if ((DATA_WIDTH % LIMB_WIDTH) != 0) begin : g_bad_limb
    $error("DATA_WIDTH must be a multiple of LIMB_WIDTH");
  end
  if ((N % MUL_LANES) != 0) begin : g_bad_lanes
    $error("limb count must be a multiple of MUL_LANES");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic [PW-1:0]            product_q, product_d;
  logic [PW-1:0]            acc_q, acc_d;
  logic [P-1:0][GRP-1:0]    a_q, a_d;
  logic [N-1:0][LW-1:0]     b_q, b_d;
  logic [IW-1:0]            i_q, i_d;
  logic [JW-1:0]            j_q, j_d;

  logic [GRP-1:0]                    a_grp;
  logic [LW-1:0]                     b_limb;
  logic [MUL_LANES-1:0][2*LW-1:0]    lane_prod;
  logic [GW-1:0]                     grp_sum;
  logic [SW-1:0]                     acc_off;
  logic [PW-1:0]                     acc_sum;
  logic                              last_step;

  // One lane group times one dat2 limb; the group sum is at most
  // (MUL_LANES+1) limbs wide, so it drops into the accumulator at a
  // single limb offset without any truncation.
  always_comb begin
    a_grp   = a_q[j_q];
    b_limb  = b_q[i_q];
    grp_sum = '0;
    for (int k = 0; k < MUL_LANES; k++) begin
      lane_prod[k] = {{LW{1'b0}}, a_grp[k*LW +: LW]} *
                     {{LW{1'b0}}, b_limb};
      grp_sum = grp_sum + (GW'(lane_prod[k]) << (k * LW));
    end
    acc_off = (SW'(j_q) * SW'(MUL_LANES) + SW'(i_q)) *
              SW'(LIMB_WIDTH);
    acc_sum = acc_q + (PW'(grp_sum) << acc_off);
    last_step = (i_q == IW'(N - 1)) && (j_q == JW'(P - 1));
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    product_d   = product_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    i_d         = i_q;
    j_d         = j_q;
    unique case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = dat1;
          b_d        = dat2;
          acc_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          i_d        = '0;
          j_d        = '0;
          if ((dat1 == '0) || (dat2 == '0)) begin
            product_d   = '0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_sum;
        if (last_step) begin
          product_d   = acc_sum;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (j_q == JW'(P - 1)) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      product_q   <= product_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      i_q         <= i_d;
      j_q         <= j_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule
